// File: rtl/cmp_stream_pkg.sv
// Shared types and helpers for the compressor result streaming stages.
// Each serializer stage takes its frame width from here and can override it.
package cmp_stream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // square17 cascade produces dst0..dst21
  localparam int DEFAULT_WIDTH = 22;

  function automatic int cnt_bits(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  function automatic logic is_last_beat(input logic [31:0] cnt, input int width);
    return cnt == 32'(width - 1);
  endfunction

endpackage

// File: rtl/result_serializer_if.sv
// Parallel-capture / serial-emit stream bundle between the compressor and its serializer.
// The slave modport is the serializer's view; the master modport is the producer/consumer side.
interface result_serializer_if import cmp_stream_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] col;
  logic             in_valid;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             sout_first;
  logic             sout_last;

  modport slave (
    input  col, in_valid, sout_ready,
    output in_ready, sout, sout_valid, sout_first, sout_last
  );

  modport master (
    output col, in_valid, sout_ready,
    input  in_ready, sout, sout_valid, sout_first, sout_last
  );
endinterface

// File: rtl/result_serializer.sv
// Captures a WIDTH-bit compressor result and emits it one bit per beat; first beat 1 cycle after capture.
// Output stalls on sout_ready=0; in_ready is the registered hold-empty flag, so one word can queue behind the frame in flight.
module result_serializer import cmp_stream_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  result_serializer_if.slave bus,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam int BW = cnt_bits(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic               sout_valid;
  logic               capture;
  logic               beat;
  logic               last_bit;
  logic               last_beat;
  logic [WIDTH-1:0]   shifted;

  assign sout_valid = (state_q == SHIFT);
  assign capture    = bus.in_valid & ~hold_full_q;
  assign beat       = sout_valid & bus.sout_ready;
  assign last_bit   = is_last_beat(32'(bit_cnt_q), WIDTH);
  assign last_beat  = beat & last_bit;

  // The output end of the shift register is always the bit on the wire.
  assign shifted = LSB_FIRST ? {1'b0, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], 1'b0};

  assign bus.in_ready   = ~hold_full_q;
  assign bus.sout_valid = sout_valid;
  assign bus.sout       = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];
  assign bus.sout_first = sout_valid & (bit_cnt_q == '0);
  assign bus.sout_last  = sout_valid & last_bit;
  assign frame_cnt      = frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (capture) begin
          shift_d   = bus.col;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (beat) begin
          shift_d   = shifted;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (capture && !last_beat) begin
          hold_d      = bus.col;
          hold_full_d = 1'b1;
        end
        if (last_beat) begin
          bit_cnt_d = '0;
          if (frame_cnt_q != '1) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
          // A queued word wins; otherwise a same-cycle capture skips the hold buffer.
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (capture) begin
            shift_d = bus.col;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: one LSB-first and one MSB-first instance on a shared clock/reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_result_serializer;
  import cmp_stream_pkg::*;

  localparam int W = 22;

  logic        clk;
  logic        rst_n;
  logic [15:0] lsb_frames;
  logic [15:0] msb_frames;

  int errors = 0;
  int checks = 0;
  int exp_lsb = 0;
  int exp_msb = 0;

  result_serializer_if #(.WIDTH(W)) lsb_if ();
  result_serializer_if #(.WIDTH(W)) msb_if ();

  result_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .CNT_W(16)) u_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (lsb_if),
    .frame_cnt (lsb_frames)
  );

  result_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .CNT_W(16)) u_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (msb_if),
    .frame_cnt (msb_frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    lsb_if.col = '0; lsb_if.in_valid = 1'b0; lsb_if.sout_ready = 1'b0;
    msb_if.col = '0; msb_if.in_valid = 1'b0; msb_if.sout_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (lsb_if.sout_valid !== 1'b0) begin errors++; $display("FAIL reset_sout_valid: got %b want 0", lsb_if.sout_valid); end
    checks++; if (lsb_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", lsb_if.in_ready); end
    checks++; if (lsb_if.sout !== 1'b0) begin errors++; $display("FAIL reset_sout: got %b want 0", lsb_if.sout); end
    checks++; if (lsb_if.sout_first !== 1'b0 || lsb_if.sout_last !== 1'b0) begin errors++; $display("FAIL reset_first_last: got %b%b want 00", lsb_if.sout_first, lsb_if.sout_last); end
    checks++; if (lsb_frames !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", lsb_frames); end
    checks++; if (msb_if.sout_valid !== 1'b0 || msb_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_msb: got valid=%b ready=%b want 0/1", msb_if.sout_valid, msb_if.in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [W-1:0] w;
    w = 22'h2AAAAA;
    lsb_if.sout_ready = 1'b1;
    lsb_if.col = w;
    lsb_if.in_valid = 1'b1;
    @(negedge clk);
    lsb_if.in_valid = 1'b0;
    lsb_if.col = 22'h3FFFFF;
    for (int k = 0; k < W; k++) begin
      checks++; if (lsb_if.sout_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b want 1", k, lsb_if.sout_valid); end
      checks++; if (lsb_if.sout !== w[k]) begin errors++; $display("FAIL single_bit[%0d]: got %b want %b", k, lsb_if.sout, w[k]); end
      checks++; if (lsb_if.sout_first !== (k == 0)) begin errors++; $display("FAIL single_first[%0d]: got %b want %b", k, lsb_if.sout_first, (k == 0)); end
      checks++; if (lsb_if.sout_last !== (k == W - 1)) begin errors++; $display("FAIL single_last[%0d]: got %b want %b", k, lsb_if.sout_last, (k == W - 1)); end
      @(negedge clk);
    end
    exp_lsb++;
    checks++; if (lsb_if.sout_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid: got %b want 0", lsb_if.sout_valid); end
    checks++; if (lsb_frames !== 16'(exp_lsb)) begin errors++; $display("FAIL single_frame_cnt: got %0d want %0d", lsb_frames, exp_lsb); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1;
    logic [W-1:0] w2;
    logic         eb;
    w1 = 22'h000001;
    w2 = 22'h200000;
    lsb_if.col = w1;
    lsb_if.in_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2 * W; k++) begin
      eb = (k < W) ? w1[k] : w2[k - W];
      checks++; if (lsb_if.sout_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, lsb_if.sout_valid); end
      checks++; if (lsb_if.sout !== eb) begin errors++; $display("FAIL b2b_bit[%0d]: got %b want %b", k, lsb_if.sout, eb); end
      checks++; if (lsb_if.sout_first !== (k % W == 0) || lsb_if.sout_last !== (k % W == W - 1)) begin errors++; $display("FAIL b2b_first_last[%0d]: got %b%b want %b%b", k, lsb_if.sout_first, lsb_if.sout_last, (k % W == 0), (k % W == W - 1)); end
      checks++; if (lsb_if.in_ready !== (k == 0 || k >= W)) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want %b", k, lsb_if.in_ready, (k == 0 || k >= W)); end
      if (k == 0) begin
        lsb_if.col = w2;
        lsb_if.in_valid = 1'b1;
      end else begin
        lsb_if.in_valid = 1'b0;
        lsb_if.col = 22'h15A5A5;
      end
      @(negedge clk);
    end
    exp_lsb += 2;
    checks++; if (lsb_if.sout_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b want 0", lsb_if.sout_valid); end
    checks++; if (lsb_frames !== 16'(exp_lsb)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want %0d", lsb_frames, exp_lsb); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w;
    int           beats;
    int           cyc;
    logic         prev_stall;
    logic         ps, pf, pl;
    w = 22'h155555;
    beats = 0;
    cyc = 0;
    prev_stall = 1'b0;
    ps = 1'b0; pf = 1'b0; pl = 1'b0;
    lsb_if.col = w;
    lsb_if.in_valid = 1'b1;
    @(negedge clk);
    lsb_if.in_valid = 1'b0;
    lsb_if.col = '0;
    while (lsb_if.sout_valid === 1'b1 && cyc < 300) begin
      if (prev_stall) begin
        checks++; if (lsb_if.sout !== ps || lsb_if.sout_first !== pf || lsb_if.sout_last !== pl) begin errors++; $display("FAIL bp_stable[%0d]: got %b%b%b want %b%b%b", cyc, lsb_if.sout, lsb_if.sout_first, lsb_if.sout_last, ps, pf, pl); end
      end
      if (beats < W) begin
        checks++; if (lsb_if.sout !== w[beats]) begin errors++; $display("FAIL bp_bit[%0d]: got %b want %b", beats, lsb_if.sout, w[beats]); end
        checks++; if (lsb_if.sout_first !== (beats == 0) || lsb_if.sout_last !== (beats == W - 1)) begin errors++; $display("FAIL bp_first_last[%0d]: got %b%b want %b%b", beats, lsb_if.sout_first, lsb_if.sout_last, (beats == 0), (beats == W - 1)); end
      end
      lsb_if.sout_ready = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      prev_stall = ~lsb_if.sout_ready;
      ps = lsb_if.sout; pf = lsb_if.sout_first; pl = lsb_if.sout_last;
      if (lsb_if.sout_ready) beats++;
      cyc++;
      @(negedge clk);
    end
    lsb_if.sout_ready = 1'b1;
    exp_lsb++;
    checks++; if (beats !== W) begin errors++; $display("FAIL bp_beats: got %0d want %0d", beats, W); end
    checks++; if (lsb_if.sout_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b want 0", lsb_if.sout_valid); end
    checks++; if (lsb_frames !== 16'(exp_lsb)) begin errors++; $display("FAIL bp_frame_cnt: got %0d want %0d", lsb_frames, exp_lsb); end
  endtask

  task automatic test_bypass();
    logic [W-1:0] wa;
    logic [W-1:0] wb;
    wa = 22'h3FFFFE;
    wb = 22'h000001;
    lsb_if.col = wa;
    lsb_if.in_valid = 1'b1;
    @(negedge clk);
    lsb_if.in_valid = 1'b0;
    lsb_if.col = 22'h155555;
    for (int k = 0; k < W; k++) begin
      checks++; if (lsb_if.sout !== wa[k]) begin errors++; $display("FAIL bypass_a_bit[%0d]: got %b want %b", k, lsb_if.sout, wa[k]); end
      if (k == W - 1) begin
        checks++; if (lsb_if.sout_last !== 1'b1 || lsb_if.in_ready !== 1'b1) begin errors++; $display("FAIL bypass_last_beat: got last=%b ready=%b want 1/1", lsb_if.sout_last, lsb_if.in_ready); end
        lsb_if.col = wb;
        lsb_if.in_valid = 1'b1;
      end
      @(negedge clk);
    end
    lsb_if.in_valid = 1'b0;
    exp_lsb++;
    checks++; if (lsb_if.sout_valid !== 1'b1 || lsb_if.sout_first !== 1'b1) begin errors++; $display("FAIL bypass_no_idle: got valid=%b first=%b want 1/1", lsb_if.sout_valid, lsb_if.sout_first); end
    checks++; if (lsb_if.in_ready !== 1'b1) begin errors++; $display("FAIL bypass_hold_empty: got %b want 1", lsb_if.in_ready); end
    checks++; if (lsb_frames !== 16'(exp_lsb)) begin errors++; $display("FAIL bypass_frame_cnt_a: got %0d want %0d", lsb_frames, exp_lsb); end
    for (int k = 0; k < W; k++) begin
      checks++; if (lsb_if.sout !== wb[k] || lsb_if.sout_valid !== 1'b1) begin errors++; $display("FAIL bypass_b_bit[%0d]: got %b valid=%b want %b", k, lsb_if.sout, lsb_if.sout_valid, wb[k]); end
      lsb_if.col = W'($urandom);
      @(negedge clk);
    end
    exp_lsb++;
    checks++; if (lsb_if.sout_valid !== 1'b0) begin errors++; $display("FAIL bypass_end_valid: got %b want 0", lsb_if.sout_valid); end
    checks++; if (lsb_frames !== 16'(exp_lsb)) begin errors++; $display("FAIL bypass_frame_cnt_b: got %0d want %0d", lsb_frames, exp_lsb); end
  endtask

  task automatic test_msb_first();
    logic [W-1:0] w;
    w = 22'h000001;
    msb_if.sout_ready = 1'b1;
    msb_if.col = w;
    msb_if.in_valid = 1'b1;
    @(negedge clk);
    msb_if.in_valid = 1'b0;
    msb_if.col = '1;
    for (int k = 0; k < W; k++) begin
      checks++; if (msb_if.sout !== w[W - 1 - k] || msb_if.sout_valid !== 1'b1) begin errors++; $display("FAIL msb_bit[%0d]: got %b valid=%b want %b", k, msb_if.sout, msb_if.sout_valid, w[W - 1 - k]); end
      checks++; if (msb_if.sout_first !== (k == 0) || msb_if.sout_last !== (k == W - 1)) begin errors++; $display("FAIL msb_first_last[%0d]: got %b%b want %b%b", k, msb_if.sout_first, msb_if.sout_last, (k == 0), (k == W - 1)); end
      @(negedge clk);
    end
    exp_msb++;
    checks++; if (msb_if.sout_valid !== 1'b0) begin errors++; $display("FAIL msb_end_valid: got %b want 0", msb_if.sout_valid); end
    checks++; if (msb_frames !== 16'(exp_msb)) begin errors++; $display("FAIL msb_frame_cnt: got %0d want %0d", msb_frames, exp_msb); end
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] w;
    lsb_if.col = 22'h3FFFFF;
    lsb_if.in_valid = 1'b1;
    @(negedge clk);
    lsb_if.col = 22'h2AAAAA;
    @(negedge clk);
    lsb_if.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (lsb_if.sout_valid !== 1'b1 || lsb_if.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_pre: got valid=%b ready=%b want 1/0", lsb_if.sout_valid, lsb_if.in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (lsb_if.sout_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", lsb_if.sout_valid); end
    checks++; if (lsb_if.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b want 1", lsb_if.in_ready); end
    checks++; if (lsb_frames !== 16'd0 || msb_frames !== 16'd0) begin errors++; $display("FAIL midrst_frame_cnt: got %0d/%0d want 0/0", lsb_frames, msb_frames); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_lsb = 0;
    exp_msb = 0;
    @(negedge clk);
    checks++; if (lsb_if.sout_valid !== 1'b0 || lsb_if.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_after: got valid=%b ready=%b want 0/1", lsb_if.sout_valid, lsb_if.in_ready); end
    w = 22'h000002;
    lsb_if.col = w;
    lsb_if.in_valid = 1'b1;
    @(negedge clk);
    lsb_if.in_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      checks++; if (lsb_if.sout !== w[k] || lsb_if.sout_valid !== 1'b1) begin errors++; $display("FAIL midrst_new_bit[%0d]: got %b valid=%b want %b", k, lsb_if.sout, lsb_if.sout_valid, w[k]); end
      @(negedge clk);
    end
    exp_lsb++;
    checks++; if (lsb_if.sout_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_stale_frame: got valid=%b want 0", lsb_if.sout_valid); end
    checks++; if (lsb_frames !== 16'(exp_lsb)) begin errors++; $display("FAIL midrst_frame_cnt_new: got %0d want %0d", lsb_frames, exp_lsb); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_bypass();
    test_msb_first();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
